// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: cycle-type codes and the arbiter's state/master encodings.
package wb_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INC     = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN_I = 2'd1,
        ST_OWN_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        M_I = 1'b0,
        M_D = 1'b1
    } master_t;

    function automatic logic is_burst_cti(input logic [2:0] cti);
        return (cti == CTI_CONST) || (cti == CTI_INC);
    endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// Stall watchdog: counts cycles of an unanswered strobe and emits a one-cycle expiry pulse.
module wb_arb_watchdog #(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [CNT_W-1:0] cnt;

    assign expire = en && (cnt == CNT_W'(TIMEOUT));

    // Any break in the stall (or the expiry itself) restarts the count from zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr || !en || expire) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/wb_mem_arbiter.sv
// Two-master (ICMU m0, DCMU m1) to one-slave Wishbone arbiter with cycle-locked grant and stall watchdog.
module wb_mem_arbiter
    import wb_pkg::*;
#(
    parameter int PRIO_MODE = 0,
    parameter int TIMEOUT   = 255,
    parameter int CNT_W     = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic [29:0] m0_addr_i,
    input  logic [2:0]  m0_cti_i,
    input  logic [1:0]  m0_bte_i,
    input  logic [3:0]  m0_sel_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_data_i,
    output logic [31:0] m0_data_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic [29:0] m1_addr_i,
    input  logic [2:0]  m1_cti_i,
    input  logic [1:0]  m1_bte_i,
    input  logic [3:0]  m1_sel_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_data_i,
    output logic [31:0] m1_data_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [29:0] s_addr_o,
    output logic [2:0]  s_cti_o,
    output logic [1:0]  s_bte_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_data_o,
    input  logic [31:0] s_data_i,
    input  logic        s_ack_i,
    input  logic        s_err_i
);

    arb_state_t state;
    master_t    rr_last;
    logic       owning;
    logic       owner_stb;
    logic       wd_en;
    logic       wd_err;

    assign owning    = (state == ST_OWN_I) || (state == ST_OWN_D);
    assign owner_stb = (state == ST_OWN_I) ? m0_stb_i :
                       (state == ST_OWN_D) ? m1_stb_i : 1'b0;
    assign wd_en     = owner_stb && !s_ack_i && !s_err_i;

    wb_arb_watchdog #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (!owning),
        .en     (wd_en),
        .expire (wd_err)
    );

    // Grant is taken only from IDLE and held until the owner drops cyc, so every
    // handover passes through one IDLE cycle and bursts are never split.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            rr_last <= M_D;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (m0_cyc_i && m1_cyc_i) begin
                        if ((PRIO_MODE != 0) || (rr_last == M_I)) state <= ST_OWN_D;
                        else                                      state <= ST_OWN_I;
                    end else if (m0_cyc_i) begin
                        state <= ST_OWN_I;
                    end else if (m1_cyc_i) begin
                        state <= ST_OWN_D;
                    end
                end
                ST_OWN_I: begin
                    if (!m0_cyc_i) begin
                        state   <= ST_IDLE;
                        rr_last <= M_I;
                    end
                end
                ST_OWN_D: begin
                    if (!m1_cyc_i) begin
                        state   <= ST_IDLE;
                        rr_last <= M_D;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign m0_data_o = s_data_i;
    assign m1_data_o = s_data_i;

    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_addr_o = '0;
        s_cti_o  = CTI_CLASSIC;
        s_bte_o  = '0;
        s_sel_o  = '0;
        s_data_o = '0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        case (state)
            ST_OWN_I: begin
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i && !wd_err;
                s_we_o   = m0_we_i;
                s_addr_o = m0_addr_i;
                s_cti_o  = m0_cti_i;
                s_bte_o  = m0_bte_i;
                s_sel_o  = m0_sel_i;
                s_data_o = m0_data_i;
                m0_ack_o = s_ack_i;
                m0_err_o = s_err_i || wd_err;
            end
            ST_OWN_D: begin
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i && !wd_err;
                s_we_o   = m1_we_i;
                s_addr_o = m1_addr_i;
                s_cti_o  = m1_cti_i;
                s_bte_o  = m1_bte_i;
                s_sel_o  = m1_sel_i;
                s_data_o = m1_data_i;
                m1_ack_o = s_ack_i;
                m1_err_o = s_err_i || wd_err;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Directed bench: a round-robin arbiter (TIMEOUT=4) and a fixed-priority arbiter share one set of stimulus.
module tb_wb_mem_arbiter;
    import wb_pkg::*;

    localparam logic [29:0] ADDR_I = 30'h0000100;
    localparam logic [29:0] ADDR_D = 30'h0000200;
    localparam logic [31:0] RDATA  = 32'hCAFE0001;

    logic        clk, rst;
    logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
    logic [29:0] m0_addr, m1_addr;
    logic [2:0]  m0_cti, m1_cti;
    logic [1:0]  m0_bte, m1_bte;
    logic [3:0]  m0_sel, m1_sel;
    logic [31:0] m0_wdat, m1_wdat, s_rdat;
    logic        s_ack, s_err;

    logic [31:0] r_m0_data, r_m1_data, p_m0_data, p_m1_data;
    logic        r_m0_ack, r_m0_err, r_m1_ack, r_m1_err;
    logic        p_m0_ack, p_m0_err, p_m1_ack, p_m1_err;
    logic        r_s_cyc, r_s_stb, r_s_we, p_s_cyc, p_s_stb, p_s_we;
    logic [29:0] r_s_addr, p_s_addr;
    logic [2:0]  r_s_cti, p_s_cti;
    logic [1:0]  r_s_bte, p_s_bte;
    logic [3:0]  r_s_sel, p_s_sel;
    logic [31:0] r_s_data, p_s_data;

    int total = 0;
    int bad   = 0;

    wb_mem_arbiter #(.PRIO_MODE(0), .TIMEOUT(4), .CNT_W(8)) dut_rr (
        .clk(clk), .rst(rst),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_addr_i(m0_addr), .m0_cti_i(m0_cti),
        .m0_bte_i(m0_bte), .m0_sel_i(m0_sel), .m0_we_i(m0_we), .m0_data_i(m0_wdat),
        .m0_data_o(r_m0_data), .m0_ack_o(r_m0_ack), .m0_err_o(r_m0_err),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_addr_i(m1_addr), .m1_cti_i(m1_cti),
        .m1_bte_i(m1_bte), .m1_sel_i(m1_sel), .m1_we_i(m1_we), .m1_data_i(m1_wdat),
        .m1_data_o(r_m1_data), .m1_ack_o(r_m1_ack), .m1_err_o(r_m1_err),
        .s_cyc_o(r_s_cyc), .s_stb_o(r_s_stb), .s_we_o(r_s_we), .s_addr_o(r_s_addr),
        .s_cti_o(r_s_cti), .s_bte_o(r_s_bte), .s_sel_o(r_s_sel), .s_data_o(r_s_data),
        .s_data_i(s_rdat), .s_ack_i(s_ack), .s_err_i(s_err)
    );

    wb_mem_arbiter #(.PRIO_MODE(1), .TIMEOUT(255), .CNT_W(8)) dut_pr (
        .clk(clk), .rst(rst),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_addr_i(m0_addr), .m0_cti_i(m0_cti),
        .m0_bte_i(m0_bte), .m0_sel_i(m0_sel), .m0_we_i(m0_we), .m0_data_i(m0_wdat),
        .m0_data_o(p_m0_data), .m0_ack_o(p_m0_ack), .m0_err_o(p_m0_err),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_addr_i(m1_addr), .m1_cti_i(m1_cti),
        .m1_bte_i(m1_bte), .m1_sel_i(m1_sel), .m1_we_i(m1_we), .m1_data_i(m1_wdat),
        .m1_data_o(p_m1_data), .m1_ack_o(p_m1_ack), .m1_err_o(p_m1_err),
        .s_cyc_o(p_s_cyc), .s_stb_o(p_s_stb), .s_we_o(p_s_we), .s_addr_o(p_s_addr),
        .s_cti_o(p_s_cti), .s_bte_o(p_s_bte), .s_sel_o(p_s_sel), .s_data_o(p_s_data),
        .s_data_i(s_rdat), .s_ack_i(s_ack), .s_err_i(s_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout obs=running exp=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    logic [2:0] burst_cti [4];

    initial begin
        burst_cti[0] = CTI_INC; burst_cti[1] = CTI_INC;
        burst_cti[2] = CTI_INC; burst_cti[3] = CTI_EOB;

        rst = 1'b0;
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_addr = ADDR_I; m0_cti = CTI_CLASSIC; m0_bte = 2'b00;
        m0_sel = 4'hF; m0_we = 1'b0; m0_wdat = 32'h11110000;
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_addr = ADDR_D; m1_cti = CTI_CLASSIC; m1_bte = 2'b00;
        m1_sel = 4'h3; m1_we = 1'b1; m1_wdat = 32'h22220000;
        s_rdat = RDATA; s_ack = 1'b1; s_err = 1'b1;

        // Reset held with both masters requesting and the slave answering
        repeat (2) @(negedge clk);
        check_output("rst_s_cyc", r_s_cyc, 0);
        check_output("rst_s_stb", r_s_stb, 0);
        check_output("rst_s_addr", r_s_addr, 0);
        check_output("rst_m0_ack", r_m0_ack, 0);
        check_output("rst_m1_ack", r_m1_ack, 0);
        check_output("rst_m0_err", r_m0_err, 0);
        s_ack = 1'b0; s_err = 1'b0; rst = 1'b1;

        @(negedge clk);
        check_output("grant_i1_cyc", r_s_cyc, 1);
        check_output("grant_i1_addr", r_s_addr, ADDR_I);
        check_output("grant_i1_sel", r_s_sel, 4'hF);

        // m0 drops cyc in the same cycle its ack arrives
        s_ack = 1'b1; m0_cyc = 1'b0; m0_stb = 1'b0; #1;
        check_output("drop_m0_ack", r_m0_ack, 1);
        check_output("drop_m1_ack", r_m1_ack, 0);
        check_output("drop_m0_data", r_m0_data, RDATA);

        @(negedge clk);
        s_ack = 1'b0;
        check_output("gap1_s_cyc", r_s_cyc, 0);
        m0_cyc = 1'b1; m0_stb = 1'b1;

        @(negedge clk);
        check_output("grant_d1_addr", r_s_addr, ADDR_D);
        check_output("grant_d1_we", r_s_we, 1);
        check_output("grant_d1_wdat", r_s_data, 32'h22220000);
        s_ack = 1'b1; m1_cyc = 1'b0; m1_stb = 1'b0; #1;
        check_output("d1_m1_ack", r_m1_ack, 1);
        check_output("d1_m0_ack", r_m0_ack, 0);

        @(negedge clk);
        s_ack = 1'b0;
        check_output("gap2_s_cyc", r_s_cyc, 0);
        m1_cyc = 1'b1; m1_stb = 1'b1;

        @(negedge clk);
        check_output("grant_i2_addr", r_s_addr, ADDR_I);
        s_ack = 1'b1; m0_cyc = 1'b0; m0_stb = 1'b0; #1;
        check_output("i2_m0_ack", r_m0_ack, 1);

        @(negedge clk);
        s_ack = 1'b0;
        check_output("gap3_s_cyc", r_s_cyc, 0);
        m0_cyc = 1'b1; m0_stb = 1'b1;

        @(negedge clk);
        check_output("grant_d2_addr", r_s_addr, ADDR_D);

        // m1 four-beat incrementing burst while m0 keeps requesting
        for (int i = 0; i < 4; i++) begin
            m1_cti = burst_cti[i]; s_ack = 1'b1; #1;
            check_output($sformatf("burst%0d_cti", i), r_s_cti, burst_cti[i]);
            check_output($sformatf("burst%0d_m1_ack", i), r_m1_ack, 1);
            check_output($sformatf("burst%0d_m0_ack", i), r_m0_ack, 0);
            check_output($sformatf("burst%0d_addr", i), r_s_addr, ADDR_D);
            @(negedge clk);
        end
        s_ack = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0; m1_cti = CTI_CLASSIC; #1;
        check_output("burst_end_addr", r_s_addr, ADDR_D);
        @(negedge clk);
        check_output("burst_gap_s_cyc", r_s_cyc, 0);
        @(negedge clk);
        check_output("post_burst_addr", r_s_addr, ADDR_I);
        check_output("wd_n0_stb", r_s_stb, 1);

        // Slave never answers m0: watchdog fires on the fourth cycle after strobe
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            check_output($sformatf("wd_n%0d_err", i), r_m0_err, 0);
            check_output($sformatf("wd_n%0d_stb", i), r_s_stb, 1);
        end
        @(negedge clk);
        check_output("wd_n4_err", r_m0_err, 1);
        check_output("wd_n4_stb", r_s_stb, 0);
        check_output("wd_n4_m1_err", r_m1_err, 0);
        @(negedge clk);
        check_output("wd_n5_err", r_m0_err, 0);
        check_output("wd_n5_stb", r_s_stb, 1);
        s_err = 1'b1; #1;
        check_output("slave_err_pass", r_m0_err, 1);
        @(negedge clk);
        s_err = 1'b0;
        repeat (4) @(negedge clk);
        s_ack = 1'b1; #1;
        check_output("ack_wins_err", r_m0_err, 0);
        check_output("ack_wins_ack", r_m0_ack, 1);
        check_output("ack_wins_stb", r_s_stb, 1);
        @(negedge clk);
        s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;

        // Fixed priority: both request continuously after a fresh reset
        rst = 1'b0; m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_output("prio_grant1_addr", p_s_addr, ADDR_D);
        check_output("prio_grant1_cyc", p_s_cyc, 1);
        check_output("rr_tie_after_rst", r_s_addr, ADDR_I);
        s_ack = 1'b1; m1_cyc = 1'b0; m1_stb = 1'b0; #1;
        check_output("prio_m1_ack", p_m1_ack, 1);
        check_output("prio_m0_ack", p_m0_ack, 0);
        @(negedge clk);
        s_ack = 1'b0;
        check_output("prio_gap_cyc", p_s_cyc, 0);
        m1_cyc = 1'b1; m1_stb = 1'b1;
        @(negedge clk);
        check_output("prio_grant2_addr", p_s_addr, ADDR_D);

        // Reset asserted during beat 2 of an m1 burst
        rst = 1'b0;
        @(negedge clk);
        m0_cyc = 1'b0; m0_stb = 1'b0; rst = 1'b1;
        @(negedge clk);
        check_output("rb_grant_addr", r_s_addr, ADDR_D);
        m1_cti = CTI_INC; s_ack = 1'b1; #1;
        check_output("rb_beat1_ack", r_m1_ack, 1);
        @(negedge clk);
        rst = 1'b0; #1;
        check_output("rb_s_cyc", r_s_cyc, 0);
        check_output("rb_s_stb", r_s_stb, 0);
        check_output("rb_m1_ack", r_m1_ack, 0);
        check_output("rb_s_cti", r_s_cti, 0);
        check_output("rb_s_addr", r_s_addr, 0);
        @(negedge clk);
        s_ack = 1'b0; m1_cti = CTI_CLASSIC; m0_cyc = 1'b1; m0_stb = 1'b1; rst = 1'b1;
        @(negedge clk);
        check_output("rb_fresh_addr", r_s_addr, ADDR_I);
        check_output("rb_fresh_cyc", r_s_cyc, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
